// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive bit sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } rx_state_t;

    // Oversample ticks per bit unless overridden at the top level.
    localparam int OVS_DEFAULT = 16;

    // Encoding of the stop_sel configuration input.
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_ovs_tick.sv
// Oversample tick generator: one tick every D clocks, D = max(divisor, 1).
// The tick is a combinational decode of the counter so that the sequencer
// sees it in the same cycle the counter reaches its terminal value.
module uart_ovs_tick
    import uart_rx_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [DW-1:0] divisor,
    output logic          tick
);

    logic [DW-1:0] cnt_r;
    logic [DW-1:0] div_s;
    logic [DW-1:0] last_s;

    // Clamp a zero divisor to 1, find the terminal count and decode the tick.
    always_comb begin
        div_s  = divisor;
        last_s = {DW{1'b0}};
        tick   = 1'b0;
        if (divisor == {DW{1'b0}}) begin
            div_s = {{(DW-1){1'b0}}, 1'b1};
        end else begin
            div_s = divisor;
        end
        last_s = div_s - {{(DW-1){1'b0}}, 1'b1};
        if (clr) begin
            tick = 1'b0;
        end else begin
            tick = (cnt_r == last_s);
        end
    end

    // Free-running 0..D-1 counter, held at zero while cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {DW{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {DW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_rx_seq.sv
// UART receive bit sequencer: synchronizes rx, validates the start bit at
// its centre, strobes each data/parity bit at its centre and checks stop
// framing. All outputs are registered.
module uart_rx_seq
    import uart_rx_pkg::*;
#(
    parameter int OVS = OVS_DEFAULT,
    parameter int DW  = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_en,
    input  logic          rx,
    input  logic [DW-1:0] baud_divisor,
    input  logic          parity_sel,
    input  logic          stop_sel,
    output logic          rx_bit,
    output logic          shift_en,
    output logic          par_en,
    output logic [2:0]    bit_idx,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic          break_det
);

    localparam int OVS_W = $clog2(OVS);
    localparam logic [OVS_W-1:0] HALF_LAST = OVS_W'(OVS/2 - 1);
    localparam logic [OVS_W-1:0] FULL_LAST = OVS_W'(OVS - 1);

    rx_state_t        state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             rx_d_r;
    logic             rx_s;
    logic             rx_fall_s;
    logic             stop_bad_s;
    logic             tick_clr_s;
    logic             tick_s;
    logic [OVS_W-1:0] ovs_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [DW-1:0]    div_r;
    logic             par_on_r;
    logic             stop2_r;
    logic             err_pend_r;
    logic             data_or_r;
    logic             rx_bit_r;
    logic             shift_en_r;
    logic             par_en_r;
    logic [2:0]       bit_idx_r;
    logic             busy_r;
    logic             frame_done_r;
    logic             frame_err_r;
    logic             break_det_r;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            rx_d_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            rx_d_r  <= sync2_r;
        end
    end

    // Edge decode, stop-bit verdict and tick-generator clear.
    always_comb begin
        rx_s       = sync2_r;
        rx_fall_s  = rx_d_r & ~sync2_r;
        stop_bad_s = err_pend_r | ~sync2_r;
        tick_clr_s = 1'b0;
        if ((state_r == IDLE) || !rx_en) begin
            tick_clr_s = 1'b1;
        end else begin
            tick_clr_s = 1'b0;
        end
    end

    uart_ovs_tick #(
        .DW (DW)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clr     (tick_clr_s),
        .divisor (div_r),
        .tick    (tick_s)
    );

    // Frame state machine with registered strobes and framing status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            ovs_cnt_r    <= {OVS_W{1'b0}};
            bit_cnt_r    <= 3'd0;
            div_r        <= {DW{1'b0}};
            par_on_r     <= 1'b0;
            stop2_r      <= 1'b0;
            err_pend_r   <= 1'b0;
            data_or_r    <= 1'b0;
            rx_bit_r     <= 1'b1;
            shift_en_r   <= 1'b0;
            par_en_r     <= 1'b0;
            bit_idx_r    <= 3'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            break_det_r  <= 1'b0;
        end else begin
            shift_en_r   <= 1'b0;
            par_en_r     <= 1'b0;
            frame_done_r <= 1'b0;
            if (!rx_en) begin
                // Abort wins over any sampling tick in the same cycle.
                state_r   <= IDLE;
                busy_r    <= 1'b0;
                bit_idx_r <= 3'd0;
                bit_cnt_r <= 3'd0;
                ovs_cnt_r <= {OVS_W{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (rx_fall_s) begin
                            state_r    <= START;
                            busy_r     <= 1'b1;
                            ovs_cnt_r  <= {OVS_W{1'b0}};
                            bit_cnt_r  <= 3'd0;
                            div_r      <= baud_divisor;
                            par_on_r   <= parity_sel;
                            err_pend_r <= 1'b0;
                            data_or_r  <= 1'b0;
                            case (stop_sel)
                                STOP_ONE: stop2_r <= 1'b0;
                                STOP_TWO: stop2_r <= 1'b1;
                                default:  stop2_r <= 1'b0;
                            endcase
                        end
                    end
                    START: begin
                        if (tick_s) begin
                            if (ovs_cnt_r == HALF_LAST) begin
                                ovs_cnt_r <= {OVS_W{1'b0}};
                                if (!rx_s) begin
                                    state_r <= DATA;
                                end else begin
                                    // Line was back high at the centre: glitch.
                                    state_r <= IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end else begin
                                ovs_cnt_r <= ovs_cnt_r + {{(OVS_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    DATA: begin
                        if (tick_s) begin
                            if (ovs_cnt_r == FULL_LAST) begin
                                ovs_cnt_r  <= {OVS_W{1'b0}};
                                rx_bit_r   <= rx_s;
                                shift_en_r <= 1'b1;
                                bit_idx_r  <= bit_cnt_r;
                                bit_cnt_r  <= bit_cnt_r + 3'd1;
                                data_or_r  <= data_or_r | rx_s;
                                if (bit_cnt_r == 3'd7) begin
                                    state_r <= par_on_r ? PARITY : STOP1;
                                end
                            end else begin
                                ovs_cnt_r <= ovs_cnt_r + {{(OVS_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    PARITY: begin
                        if (tick_s) begin
                            if (ovs_cnt_r == FULL_LAST) begin
                                ovs_cnt_r <= {OVS_W{1'b0}};
                                rx_bit_r  <= rx_s;
                                par_en_r  <= 1'b1;
                                state_r   <= STOP1;
                            end else begin
                                ovs_cnt_r <= ovs_cnt_r + {{(OVS_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    STOP1, STOP2: begin
                        if (tick_s) begin
                            if (ovs_cnt_r == FULL_LAST) begin
                                ovs_cnt_r <= {OVS_W{1'b0}};
                                rx_bit_r  <= rx_s;
                                if ((state_r == STOP1) && stop2_r) begin
                                    err_pend_r <= stop_bad_s;
                                    state_r    <= STOP2;
                                end else begin
                                    state_r      <= IDLE;
                                    busy_r       <= 1'b0;
                                    frame_done_r <= 1'b1;
                                    frame_err_r  <= stop_bad_s;
                                    break_det_r  <= stop_bad_s & ~data_or_r;
                                end
                            end else begin
                                ovs_cnt_r <= ovs_cnt_r + {{(OVS_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_bit     = rx_bit_r;
    assign shift_en   = shift_en_r;
    assign par_en     = par_en_r;
    assign bit_idx    = bit_idx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign break_det  = break_det_r;

endmodule

// File: tb/tb_uart_rx_seq.sv
// Scoreboard bench for uart_rx_seq: frames are driven bit by bit, the
// expected strobes and frame results are queued, and a negedge monitor
// pops and compares them as the sequencer produces them.
module tb_uart_rx_seq;

    localparam int OVS = 16;
    localparam int DW  = 12;

    logic          clk;
    logic          reset;
    logic          rx_en;
    logic          rx;
    logic [DW-1:0] baud_divisor;
    logic          parity_sel;
    logic          stop_sel;
    logic          rx_bit;
    logic          shift_en;
    logic          par_en;
    logic [2:0]    bit_idx;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic          break_det;

    logic [3:0] bit_q[$];   // {bit_idx, rx_bit}
    logic       par_q[$];   // parity bit value
    logic [1:0] done_q[$];  // {frame_err, break_det}

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last_shift = 0;
    int cur_d     = 4;
    int shift_cnt = 0;
    int par_cnt   = 0;
    int done_cnt  = 0;

    uart_rx_seq #(
        .OVS (OVS),
        .DW  (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .rx           (rx),
        .baud_divisor (baud_divisor),
        .parity_sel   (parity_sel),
        .stop_sel     (stop_sel),
        .rx_bit       (rx_bit),
        .shift_en     (shift_en),
        .par_en       (par_en),
        .bit_idx      (bit_idx),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .break_det    (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare every strobe and frame end against the queues.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [1:0] f;
        logic       p;
        cyc++;
        if (reset && shift_en) begin
            shift_cnt++;
            total_cnt++;
            if (bit_q.size() == 0) begin
                $display("FAIL unexpected_shift: got idx %0d bit %0b, expected no strobe", bit_idx, rx_bit);
            end else begin
                e = bit_q.pop_front();
                if ({bit_idx, rx_bit} !== e) begin
                    $display("FAIL shift_data: got idx %0d bit %0b, expected idx %0d bit %0b",
                             bit_idx, rx_bit, e[3:1], e[0]);
                end else begin
                    pass_cnt++;
                end
                if (e[3:1] != 3'd0) begin
                    total_cnt++;
                    if ((cyc - last_shift) !== OVS * cur_d) begin
                        $display("FAIL strobe_spacing: got %0d cycles, expected %0d", cyc - last_shift, OVS * cur_d);
                    end else begin
                        pass_cnt++;
                    end
                end
            end
            last_shift = cyc;
        end
        if (reset && par_en) begin
            par_cnt++;
            total_cnt++;
            if (par_q.size() == 0) begin
                $display("FAIL unexpected_par: got par_en with bit %0b, expected none", rx_bit);
            end else begin
                p = par_q.pop_front();
                if (rx_bit !== p) begin
                    $display("FAIL par_bit: got %0b, expected %0b", rx_bit, p);
                end else begin
                    pass_cnt++;
                end
            end
        end
        if (reset && frame_done) begin
            done_cnt++;
            total_cnt++;
            if (done_q.size() == 0) begin
                $display("FAIL unexpected_done: got frame_done, expected none");
            end else begin
                f = done_q.pop_front();
                if ({frame_err, break_det, busy} !== {f, 1'b0}) begin
                    $display("FAIL frame_status: got err %0b brk %0b busy %0b, expected err %0b brk %0b busy 0",
                             frame_err, break_det, busy, f[1], f[0]);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    task automatic drive_bit(input logic v, input int d);
        @(posedge clk);
        rx = v;
        repeat (OVS * d - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_on, input logic two_stop,
                              input logic s1, input logic s2, input int d);
        baud_divisor = DW'(d);
        parity_sel   = par_on;
        stop_sel     = two_stop;
        cur_d        = d;
        drive_bit(1'b0, d);
        for (int i = 0; i < 8; i++) drive_bit(b[i], d);
        if (par_on) drive_bit(^b, d);
        drive_bit(s1, d);
        if (two_stop) drive_bit(s2, d);
        rx = 1'b1;
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) bit_q.push_back({3'(i), b[i]});
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({rx_bit, shift_en, par_en, bit_idx, busy, frame_done, frame_err, break_det} !== 10'b1_0_0_000_0_0_0_0) begin
            $display("FAIL reset_values: got %b, expected 1000000000",
                     {rx_bit, shift_en, par_en, bit_idx, busy, frame_done, frame_err, break_det});
        end else begin
            pass_cnt++;
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        total_cnt++;
        if ({rx_bit, busy, frame_err} !== 3'b100) begin
            $display("FAIL idle_after_reset: got %b, expected 100", {rx_bit, busy, frame_err});
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_8n1();
        int s0 = shift_cnt;
        int p0 = par_cnt;
        int d0 = done_cnt;
        push_bits(8'hA5, 8);
        done_q.push_back(2'b00);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        idle(40);
        total_cnt++;
        if ({shift_cnt - s0, par_cnt - p0, done_cnt - d0} !== {32'd8, 32'd0, 32'd1}) begin
            $display("FAIL 8n1_counts: got shift %0d par %0d done %0d, expected 8 0 1",
                     shift_cnt - s0, par_cnt - p0, done_cnt - d0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int s0 = shift_cnt;
        int d0 = done_cnt;
        baud_divisor = 12'd4;
        cur_d = 4;
        @(posedge clk);
        rx = 1'b0;
        repeat (12) @(posedge clk);
        total_cnt++;
        if (busy !== 1'b1) begin
            $display("FAIL glitch_busy_rise: got %0b, expected 1", busy);
        end else begin
            pass_cnt++;
        end
        repeat (8) @(posedge clk);
        rx = 1'b1;
        repeat (60) @(posedge clk);
        total_cnt++;
        if ({busy, shift_cnt - s0, done_cnt - d0} !== {1'b0, 32'd0, 32'd0}) begin
            $display("FAIL glitch_reject: got busy %0b shifts %0d dones %0d, expected 0 0 0",
                     busy, shift_cnt - s0, done_cnt - d0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_8e2_bad_stop();
        int s0 = shift_cnt;
        int p0 = par_cnt;
        logic [7:0] b = 8'h3C;
        push_bits(b, 8);
        par_q.push_back(^b);
        done_q.push_back(2'b10);
        send_frame(b, 1'b1, 1'b1, 1'b1, 1'b0, 4);
        idle(80);
        total_cnt++;
        if ({shift_cnt - s0, par_cnt - p0} !== {32'd8, 32'd1}) begin
            $display("FAIL 8e2_counts: got shift %0d par %0d, expected 8 1", shift_cnt - s0, par_cnt - p0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit = 1'b0;
        push_bits(8'hA5, 6);
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 4);
            begin
                for (int i = 0; i < 2000 && !hit; i++) begin
                    @(negedge clk);
                    if (shift_en && (bit_idx == 3'd5)) hit = 1'b1;
                end
                total_cnt++;
                if (!hit) begin
                    $display("FAIL reset_mid_wait: got no bit 5 strobe, expected one within 2000 cycles");
                end else begin
                    #2;
                    reset = 1'b0;
                    #1;
                    if ({rx_bit, shift_en, par_en, bit_idx, busy, frame_done, frame_err, break_det} !== 10'b1_0_0_000_0_0_0_0) begin
                        $display("FAIL reset_mid_values: got %b, expected 1000000000",
                                 {rx_bit, shift_en, par_en, bit_idx, busy, frame_done, frame_err, break_det});
                    end else begin
                        pass_cnt++;
                    end
                end
            end
        join
        idle(5);
        reset = 1'b1;
        idle(20);
        total_cnt++;
        if ({bit_q.size(), busy} !== {32'd0, 1'b0}) begin
            $display("FAIL reset_mid_queue: got %0d pending busy %0b, expected 0 0", bit_q.size(), busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_break();
        push_bits(8'h00, 8);
        done_q.push_back(2'b11);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle(80);
        total_cnt++;
        if ({frame_err, break_det} !== 2'b11) begin
            $display("FAIL break_hold: got %b, expected 11", {frame_err, break_det});
        end else begin
            pass_cnt++;
        end
        push_bits(8'hFF, 8);
        done_q.push_back(2'b00);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        idle(40);
        total_cnt++;
        if ({frame_err, break_det, done_q.size()} !== {2'b00, 32'd0}) begin
            $display("FAIL break_clear: got %b pending %0d, expected 00 0", {frame_err, break_det}, done_q.size());
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        logic [7:0] b = 8'h5A;
        baud_divisor = 12'd4;
        parity_sel = 1'b0;
        stop_sel = 1'b0;
        cur_d = 4;
        push_bits(b, 4);
        drive_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 4);
        @(posedge clk);
        rx = b[4];
        repeat (10) @(posedge clk);
        @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, bit_idx} !== 4'b0_000) begin
            $display("FAIL abort_idle: got busy %0b idx %0d, expected 0 0", busy, bit_idx);
        end else begin
            pass_cnt++;
        end
        idle(300);
        total_cnt++;
        if ({bit_q.size(), done_cnt - d0} !== {32'd0, 32'd0}) begin
            $display("FAIL abort_outputs: got %0d missing strobes %0d dones, expected 0 0", bit_q.size(), done_cnt - d0);
        end else begin
            pass_cnt++;
        end
        rx_en = 1'b1;
        idle(5);
        push_bits(b, 8);
        done_q.push_back(2'b00);
        send_frame(b, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        idle(40);
        total_cnt++;
        if ({bit_q.size(), done_cnt - d0} !== {32'd0, 32'd1}) begin
            $display("FAIL abort_recover: got %0d pending %0d dones, expected 0 1", bit_q.size(), done_cnt - d0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int s0 = shift_cnt;
        push_bits(8'h81, 8);
        done_q.push_back(2'b00);
        push_bits(8'h81, 8);
        done_q.push_back(2'b00);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle(30);
        total_cnt++;
        if ({done_cnt - d0, shift_cnt - s0, bit_q.size()} !== {32'd2, 32'd16, 32'd0}) begin
            $display("FAIL back_to_back: got dones %0d shifts %0d pending %0d, expected 2 16 0",
                     done_cnt - d0, shift_cnt - s0, bit_q.size());
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        rx = 1'b1;
        rx_en = 1'b1;
        baud_divisor = 12'd4;
        parity_sel = 1'b0;
        stop_sel = 1'b0;
        reset = 1'b0;
        test_reset();
        test_8n1();
        test_glitch();
        test_8e2_bad_stop();
        test_reset_mid_frame();
        test_break();
        test_abort();
        test_back_to_back();
        total_cnt++;
        if ({bit_q.size(), par_q.size(), done_q.size()} !== {32'd0, 32'd0, 32'd0}) begin
            $display("FAIL final_queues: got %0d %0d %0d pending, expected 0 0 0",
                     bit_q.size(), par_q.size(), done_q.size());
        end else begin
            pass_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_seq.md
# uart_rx_seq

Bit-level sequencer for the UART receive path. Synchronizes the raw `rx` line and detects and validates the start bit with oversampling. It then emits one-cycle sample strobes at each bit centre to drive the RX shift datapath, and checks parity and stop framing. It sits between the baud configuration inputs and the RX datapath, replacing free-running bit counting with centre-aligned sampling.

## Interface
- `OVS`, 16: oversample ticks per bit; even, ≥4.
- `DW`, 12: baud divisor width.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_en` in 1: receiver enable; low aborts any frame in progress.
- `rx` in 1: raw serial line, idle high, asynchronous to `clk`.
- `baud_divisor` in DW: clk cycles per oversample tick; 0 is treated as 1.
- `parity_sel` in 1: 1 means a parity bit follows data bit 7.
- `stop_sel` in 1: 0 means one stop bit, 1 means two stop bits.
- `rx_bit` out 1: value sampled at the most recent bit centre.
- `shift_en` out 1: one-cycle strobe for a data bit; datapath shifts `rx_bit` in LSB-first.
- `par_en` out 1: one-cycle strobe for the parity bit.
- `bit_idx` out 3: index of the data bit being strobed, 0..7.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after the last stop bit is sampled.
- `frame_err` out 1: a stop bit was sampled low; valid with `frame_done`, held until the next `frame_done`.
- `break_det` out 1: all data bits 0 and a framing error; same timing as `frame_err`.

## Operation
- **Synchronizer.** Two flops, reset to 1, produce `rx_s`. Edge detection uses `rx_s` and its one-cycle delay.
- **Tick generator.** A counter runs 0..D-1, where D = max(`baud_divisor`, 1). `tick` is asserted at count D-1. The counter is cleared while in IDLE and on START entry.
- **Oversample counter.** `ovs_cnt` counts ticks and clears on every state change.
- **State machine:**
  - **IDLE.** If `rx_en` is high and `rx_s` falls, go to START.
  - **START.** On the tick where `ovs_cnt` = OVS/2-1, sample `rx_s`. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no outputs.
  - **DATA.** On the tick where `ovs_cnt` = OVS-1, sample `rx_s` into `rx_bit` and strobe `shift_en`, then increment `bit_idx`. After bit 7, go to PARITY if `parity_sel`, else to STOP1.
  - **PARITY.** Sample at centre and strobe `par_en`, then go to STOP1.
  - **STOP1 / STOP2.** Sample at centre; a low sample sets the pending error. STOP2 is entered only when `stop_sel` is 1.
  - **Frame end.** After the last stop sample, pulse `frame_done`, latch `frame_err` and `break_det`, and return to IDLE. A start edge can be accepted on the very next cycle.
- **Configuration latch.** `parity_sel`, `stop_sel` and D are captured on START entry and held constant for the frame.
- **`rx_en` low in any state.** Go to IDLE on the next clock. No `frame_done` pulse. `frame_err` and `break_det` keep their prior values. `bit_idx` is cleared.
- **Simultaneous events.** `rx_en` falling on a sampling tick means abort wins; no strobe is issued.

## Timing
- **Reset values.** `rx_bit`=1, all strobes and pulses 0, `bit_idx`=0, `busy`=0, `frame_err`=0, `break_det`=0, state IDLE.
- **All outputs registered.** Strobes assert one cycle after the sampling tick, and `rx_bit` is valid in the same cycle as its strobe.
- **Start detection.** Edge is seen 3 cycles after the pin falls (2 sync + 1 edge).
- **Bit timing.** Let T0 be the START entry cycle. The start sample tick is at T0 + (OVS/2)·D. Data bit i's tick is at T0 + (OVS/2 + OVS·(i+1))·D, and its strobe follows one cycle later.
- **Strobe spacing.** Consecutive strobes are exactly OVS·D cycles apart.
- **Frame end.** `frame_done` is asserted one cycle after the last stop tick, and `busy` falls in that same cycle.
- **Glitch rejection.** A start pulse shorter than (OVS/2)·D cycles is rejected.

## Structure
- **Package `uart_rx_pkg`:**
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - `OVS_DEFAULT` constant.
  - Stop-select encoding constants.
- **Sub-module `uart_ovs_tick`:** tick generator with synchronous clear input and divisor-0 clamp.
- **Top level:** synchronizer, state machine and framing checks remain in `uart_rx_seq`.

## Test plan
- **8N1 data.** D=4, OVS=16, 8N1, byte 0xA5 → 8 `shift_en` strobes 64 cycles apart with `rx_bit` = 1,0,1,0,0,1,0,1 and `bit_idx` 0..7. One `frame_done`; `frame_err`=0, `par_en` never asserted.
- **Glitch.** D=4, `rx` low for 20 cycles then high → `busy` rises then falls, no strobes, no `frame_done`.
- **8E2 with bad stop.** `parity_sel`=1, `stop_sel`=1, byte 0x3C, second stop bit driven 0 → 8 `shift_en`, one `par_en`, `frame_done` with `frame_err`=1 and `break_det`=0.
- **Break.** 0x00 with stop bit low → `frame_err`=1 and `break_det`=1. The following good frame 0xFF clears both at its `frame_done`.
- **Abort and recovery.** `rx_en` dropped after strobe for bit 3 → IDLE next cycle, no further strobes, no `frame_done`. After `rx_en` is re-asserted, a new frame 0x5A is received correctly.
- **Reset mid-frame.** `reset` asserted at bit 5 → all outputs return to reset values immediately, including an in-flight strobe.
- **Back-to-back frames.** D=1, two back-to-back 0x81 frames → two `frame_done` pulses, second start accepted.
